// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the decode-stage control unit: opcode values,
// integer/FP ALU op encodings, the packed ID/EX control bundle, the FSM
// state type and a small helper for sizing the FP latency counter.
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam logic [6:0] OP_RTYPE = 7'd0;
    localparam logic [6:0] OP_J     = 7'd2;
    localparam logic [6:0] OP_BEQ   = 7'd4;
    localparam logic [6:0] OP_ADDI  = 7'd8;
    localparam logic [6:0] OP_FADD  = 7'd10;
    localparam logic [6:0] OP_FSUB  = 7'd11;
    localparam logic [6:0] OP_FMUL  = 7'd12;
    localparam logic [6:0] OP_FDIV  = 7'd13;
    localparam logic [6:0] OP_LW    = 7'd35;
    localparam logic [6:0] OP_SW    = 7'd43;

    localparam logic [1:0] ALUOP_NONE   = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_ADD    = 2'b10;

    localparam logic [3:0] FPOP_ADD = 4'd0;
    localparam logic [3:0] FPOP_SUB = 4'd1;
    localparam logic [3:0] FPOP_MUL = 4'd2;
    localparam logic [3:0] FPOP_DIV = 4'd3;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_write;
        logic       mem_read;
        logic       branch;
        logic       reg_write;
        logic       mem_to_reg;
        logic       jump;
        logic       fp_instr;
        logic       if_flush;
        logic [1:0] alu_op;
        logic [3:0] fp_alu_op;
    } ctrl_bundle_t;

    typedef enum logic {
        IDLE    = 1'b0,
        FP_BUSY = 1'b1
    } state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_if
// Decode-stage bus between the pipeline and pipe_ctrl_unit.
//   master : drives opcode / instr_valid / flush, receives ID/EX controls
//   slave  : the control unit side
// Signals: opcode[6:0], instr_valid, flush (to unit); RegDst, ALUsrc,
// Memwrite, Memread, Branch, Regwrite, MemtoReg, jump, FP_instruction,
// IF_Flush, ALUop[1:0], FP_ALUop[3:0], stall, illegal (from unit).
// ---------------------------------------------------------------------------
interface pipe_ctrl_if;
    logic [6:0] opcode;
    logic       instr_valid;
    logic       flush;

    logic       RegDst;
    logic       ALUsrc;
    logic       Memwrite;
    logic       Memread;
    logic       Branch;
    logic       Regwrite;
    logic       MemtoReg;
    logic       jump;
    logic       FP_instruction;
    logic       IF_Flush;
    logic [1:0] ALUop;
    logic [3:0] FP_ALUop;
    logic       stall;
    logic       illegal;

    modport master (
        output opcode, instr_valid, flush,
        input  RegDst, ALUsrc, Memwrite, Memread, Branch, Regwrite, MemtoReg,
               jump, FP_instruction, IF_Flush, ALUop, FP_ALUop, stall, illegal
    );

    modport slave (
        input  opcode, instr_valid, flush,
        output RegDst, ALUsrc, Memwrite, Memread, Branch, Regwrite, MemtoReg,
               jump, FP_instruction, IF_Flush, ALUop, FP_ALUop, stall, illegal
    );
endinterface

// File: rtl/pipe_ctrl_decode.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_decode
// Purely combinational opcode -> control bundle map.
// Build option: PIPE_CTRL_FP_DIV_EN enables opcode 13 as FP divide; without
// it opcode 13 is reported as undefined.
// Ports:
//   opcode  in   7        ID-stage opcode
//   bundle  out  struct   decoded controls (all zero when undefined)
//   is_fp   out  1        opcode is a multi-cycle FP operation
//   fp_lat  out  CNT_W    FP unit occupancy in cycles (0 when not FP)
//   undef   out  1        opcode is not in the map
// ---------------------------------------------------------------------------
module pipe_ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int FP_ADD_LAT = 2,
    parameter int FP_SUB_LAT = 2,
    parameter int FP_MUL_LAT = 4,
`ifdef PIPE_CTRL_FP_DIV_EN
    parameter int FP_DIV_LAT = 8,
`endif
    parameter int CNT_W      = 4
) (
    input  logic [6:0]       opcode,
    output ctrl_bundle_t     bundle,
    output logic             is_fp,
    output logic [CNT_W-1:0] fp_lat,
    output logic             undef
);

    always_comb begin
        bundle = '0;
        is_fp  = 1'b0;
        fp_lat = '0;
        undef  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                bundle.reg_dst   = 1'b1;
                bundle.reg_write = 1'b1;
            end
            OP_ADDI: begin
                bundle.alu_op    = ALUOP_ADD;
                bundle.alu_src   = 1'b1;
                bundle.reg_write = 1'b1;
            end
            OP_LW: begin
                bundle.alu_op    = ALUOP_ADD;
                bundle.alu_src   = 1'b1;
                bundle.mem_read  = 1'b1;
                bundle.reg_write = 1'b1;
            end
            OP_SW: begin
                bundle.alu_op     = ALUOP_ADD;
                bundle.alu_src    = 1'b1;
                bundle.mem_write  = 1'b1;
                bundle.mem_to_reg = 1'b1;
            end
            OP_BEQ: begin
                bundle.alu_op   = ALUOP_BRANCH;
                bundle.branch   = 1'b1;
                bundle.if_flush = 1'b1;
            end
            OP_J: begin
                bundle.jump     = 1'b1;
                bundle.if_flush = 1'b1;
            end
            OP_FADD, OP_FSUB, OP_FMUL
`ifdef PIPE_CTRL_FP_DIV_EN
            , OP_FDIV
`endif
            : begin
                bundle.reg_dst   = 1'b1;
                bundle.reg_write = 1'b1;
                bundle.fp_instr  = 1'b1;
                is_fp            = 1'b1;
                case (opcode)
                    OP_FADD: begin
                        bundle.fp_alu_op = FPOP_ADD;
                        fp_lat           = CNT_W'(FP_ADD_LAT);
                    end
                    OP_FSUB: begin
                        bundle.fp_alu_op = FPOP_SUB;
                        fp_lat           = CNT_W'(FP_SUB_LAT);
                    end
                    OP_FMUL: begin
                        bundle.fp_alu_op = FPOP_MUL;
                        fp_lat           = CNT_W'(FP_MUL_LAT);
                    end
                    default: begin
`ifdef PIPE_CTRL_FP_DIV_EN
                        bundle.fp_alu_op = FPOP_DIV;
                        fp_lat           = CNT_W'(FP_DIV_LAT);
`endif
                    end
                endcase
            end
            default: undef = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_unit
// Registered decode-stage control unit. Opcode is decoded into the ID/EX
// control register one cycle later; multi-cycle FP ops hold the pipeline
// with stall while bubbles are issued; flush kills the decoded instruction.
// Build option: PIPE_CTRL_FP_DIV_EN enables FP divide (opcode 13).
// Ports:
//   clk    in   1      rising-edge clock
//   reset  in   1      asynchronous, active-high reset
//   bus    slave       pipe_ctrl_if (opcode/instr_valid/flush in,
//                      ID/EX controls, stall, illegal out)
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | decoding; each edge loads the decoded bundle (or zeros)
// FP_BUSY | FP unit occupied; stall=1, bubbles loaded, cnt counts down
// ---------------------------------------------------------------------------
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int FP_ADD_LAT = 2,
    parameter int FP_SUB_LAT = 2,
    parameter int FP_MUL_LAT = 4,
    parameter int FP_DIV_LAT = 8
) (
    input logic        clk,
    input logic        reset,
    pipe_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(max4(FP_ADD_LAT, FP_SUB_LAT, FP_MUL_LAT, FP_DIV_LAT)) + 1;

    ctrl_bundle_t     dec_bundle;
    logic             dec_is_fp;
    logic [CNT_W-1:0] dec_fp_lat;
    logic             dec_undef;

    pipe_ctrl_decode #(
        .FP_ADD_LAT (FP_ADD_LAT),
        .FP_SUB_LAT (FP_SUB_LAT),
        .FP_MUL_LAT (FP_MUL_LAT),
`ifdef PIPE_CTRL_FP_DIV_EN
        .FP_DIV_LAT (FP_DIV_LAT),
`endif
        .CNT_W      (CNT_W)
    ) u_decode (
        .opcode (bus.opcode),
        .bundle (dec_bundle),
        .is_fp  (dec_is_fp),
        .fp_lat (dec_fp_lat),
        .undef  (dec_undef)
    );

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_bundle_t     ctrl_q, ctrl_d;
    logic             illegal_q, illegal_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctrl_d    = '0;
        illegal_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.instr_valid && !bus.flush) begin
                    ctrl_d    = dec_bundle;
                    illegal_d = dec_undef;
                    // Single-cycle FP ops need no busy period.
                    if (dec_is_fp && (dec_fp_lat > CNT_W'(1))) begin
                        cnt_d   = dec_fp_lat - CNT_W'(1);
                        state_d = FP_BUSY;
                    end
                end
            end
            FP_BUSY: begin
                // The in-flight FP op is older than whatever sits in decode,
                // so flush and opcode are deliberately not looked at here.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.RegDst         = ctrl_q.reg_dst;
    assign bus.ALUsrc         = ctrl_q.alu_src;
    assign bus.Memwrite       = ctrl_q.mem_write;
    assign bus.Memread        = ctrl_q.mem_read;
    assign bus.Branch         = ctrl_q.branch;
    assign bus.Regwrite       = ctrl_q.reg_write;
    assign bus.MemtoReg       = ctrl_q.mem_to_reg;
    assign bus.jump           = ctrl_q.jump;
    assign bus.FP_instruction = ctrl_q.fp_instr;
    assign bus.IF_Flush       = ctrl_q.if_flush;
    assign bus.ALUop          = ctrl_q.alu_op;
    assign bus.FP_ALUop       = ctrl_q.fp_alu_op;
    assign bus.illegal        = illegal_q;
    assign bus.stall          = (state_q == FP_BUSY);

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
module tb_pipe_ctrl_unit;

    localparam int ADD_LAT = 1;
    localparam int SUB_LAT = 2;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 5;

    // Observation vector order:
    // {RegDst, ALUsrc, Memwrite, Memread, Branch, Regwrite, MemtoReg, jump,
    //  FP_instruction, IF_Flush, ALUop[1:0], FP_ALUop[3:0], stall, illegal}
    typedef logic [17:0] obs_t;

    localparam obs_t ZERO   = 18'b0000000000_00_0000_00;
    localparam obs_t STALL  = 18'b0000000000_00_0000_10;
    localparam obs_t ILL    = 18'b0000000000_00_0000_01;
    localparam obs_t E_R    = 18'b1000010000_00_0000_00;
    localparam obs_t E_ADDI = 18'b0100010000_10_0000_00;
    localparam obs_t E_LW   = 18'b0101010000_10_0000_00;
    localparam obs_t E_SW   = 18'b0110001000_10_0000_00;
    localparam obs_t E_BEQ  = 18'b0000100001_01_0000_00;
    localparam obs_t E_J    = 18'b0000000101_00_0000_00;
    localparam obs_t E_FADD = 18'b1000010010_00_0000_00;
    localparam obs_t E_FSUB = 18'b1000010010_00_0001_00;
    localparam obs_t E_FMUL = 18'b1000010010_00_0010_00;
    localparam obs_t E_FDIV = 18'b1000010010_00_0011_00;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_ctrl_if bus();

    pipe_ctrl_unit #(
        .FP_ADD_LAT (ADD_LAT),
        .FP_SUB_LAT (SUB_LAT),
        .FP_MUL_LAT (MUL_LAT),
        .FP_DIV_LAT (DIV_LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    function automatic obs_t observe();
        return {bus.RegDst, bus.ALUsrc, bus.Memwrite, bus.Memread, bus.Branch,
                bus.Regwrite, bus.MemtoReg, bus.jump, bus.FP_instruction,
                bus.IF_Flush, bus.ALUop, bus.FP_ALUop, bus.stall, bus.illegal};
    endfunction

    task automatic check(input string name, input obs_t exp);
        obs_t act;
        act = observe();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic v, input logic f);
        bus.opcode      = op;
        bus.instr_valid = v;
        bus.flush       = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: decode straight from the opcode table, and keep a
    // plain count of stall cycles still owed by the last accepted FP op.
    int   busy_rem;
    obs_t m_ctl;
    bit   m_ill;

    function automatic void ref_decode(input int op, output obs_t ctl, output int lat,
                                       output bit undef);
        ctl = ZERO; lat = 0; undef = 1'b0;
        case (op)
            0:  ctl = E_R;
            8:  ctl = E_ADDI;
            35: ctl = E_LW;
            43: ctl = E_SW;
            4:  ctl = E_BEQ;
            2:  ctl = E_J;
            10: begin ctl = E_FADD; lat = ADD_LAT; end
            11: begin ctl = E_FSUB; lat = SUB_LAT; end
            12: begin ctl = E_FMUL; lat = MUL_LAT; end
`ifdef PIPE_CTRL_FP_DIV_EN
            13: begin ctl = E_FDIV; lat = DIV_LAT; end
`endif
            default: undef = 1'b1;
        endcase
    endfunction

    function automatic void model_reset();
        busy_rem = 0;
        m_ctl    = ZERO;
        m_ill    = 1'b0;
    endfunction

    function automatic void model_step(input int op, input bit v, input bit f);
        obs_t c;
        int   lat;
        bit   u;
        if (busy_rem > 0) begin
            m_ctl = ZERO;
            m_ill = 1'b0;
            busy_rem--;
        end else if (v && !f) begin
            ref_decode(op, c, lat, u);
            m_ctl    = c;
            m_ill    = u;
            busy_rem = (lat > 1) ? lat - 1 : 0;
        end else begin
            m_ctl = ZERO;
            m_ill = 1'b0;
        end
    endfunction

    function automatic obs_t model_exp();
        return m_ctl | ((busy_rem > 0) ? STALL : ZERO) | (m_ill ? ILL : ZERO);
    endfunction

    typedef struct {
        logic [6:0] op;
        logic       valid;
        logic       flush;
        obs_t       exp;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic [6:0] op_pool[11];
        logic [6:0] r_op;
        logic       r_v, r_f;

        vecs[0]  = '{7'd0,   1'b1, 1'b0, E_R};
        vecs[1]  = '{7'd8,   1'b1, 1'b0, E_ADDI};
        vecs[2]  = '{7'd35,  1'b1, 1'b0, E_LW};
        vecs[3]  = '{7'd43,  1'b1, 1'b0, E_SW};
        vecs[4]  = '{7'd4,   1'b1, 1'b0, E_BEQ};
        vecs[5]  = '{7'd2,   1'b1, 1'b0, E_J};
        vecs[6]  = '{7'd10,  1'b1, 1'b0, E_FADD};
        vecs[7]  = '{7'd35,  1'b0, 1'b0, ZERO};
        vecs[8]  = '{7'd2,   1'b1, 1'b1, ZERO};
        vecs[9]  = '{7'd12,  1'b1, 1'b1, ZERO};
        vecs[10] = '{7'd63,  1'b1, 1'b0, ILL};
        vecs[11] = '{7'd127, 1'b1, 1'b0, ILL};
        vecs[12] = '{7'd0,   1'b1, 1'b0, E_R};

        // Reset state, with a valid instruction presented during reset.
        reset = 1'b1;
        drive(7'd35, 1'b1, 1'b0);
        tick();
        tick();
        check("reset_state", ZERO);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].valid, vecs[i].flush);
            tick();
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Reset in the middle of an FP busy period.
        drive(7'd12, 1'b1, 1'b0);
        tick();
        check("rst_mul_issue", E_FMUL | STALL);
        drive(7'd8, 1'b1, 1'b0);
        tick();
        check("rst_mul_busy", STALL);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_busy", ZERO);
        @(negedge clk);
        reset = 1'b0;
        drive(7'd0, 1'b1, 1'b0);
        tick();
        check("post_rst_rtype", E_R);

        // FP mul (L=4) then addi held; flush during busy is ignored.
        drive(7'd12, 1'b1, 1'b0);
        tick();
        check("mul_issue", E_FMUL | STALL);
        drive(7'd8, 1'b1, 1'b1);
        tick();
        check("mul_busy1_flush", STALL);
        drive(7'd8, 1'b1, 1'b0);
        tick();
        check("mul_busy2", STALL);
        tick();
        check("mul_last_bubble", ZERO);
        tick();
        check("addi_after_mul", E_ADDI);

        // FP add (L=1) then FP sub (L=2) then j.
        drive(7'd10, 1'b1, 1'b0);
        tick();
        check("fadd_nostall", E_FADD);
        drive(7'd11, 1'b1, 1'b0);
        tick();
        check("fsub_issue", E_FSUB | STALL);
        drive(7'd2, 1'b1, 1'b0);
        tick();
        check("fsub_bubble", ZERO);
        tick();
        check("j_after_fsub", E_J);

        // Opcode 13 behaviour depends on the build option.
`ifdef PIPE_CTRL_FP_DIV_EN
        drive(7'd13, 1'b1, 1'b0);
        tick();
        check("fdiv_issue", E_FDIV | STALL);
        drive(7'd0, 1'b1, 1'b0);
        for (int i = 1; i < DIV_LAT - 1; i++) begin
            tick();
            check($sformatf("fdiv_busy%0d", i), STALL);
        end
        tick();
        check("fdiv_last_bubble", ZERO);
        tick();
        check("rtype_after_fdiv", E_R);
`else
        drive(7'd13, 1'b1, 1'b0);
        tick();
        check("op13_illegal", ILL);
        drive(7'd13, 1'b0, 1'b0);
        tick();
        check("op13_pulse_end", ZERO);
`endif

        // Randomized run against the reference model.
        op_pool = '{7'd0, 7'd8, 7'd35, 7'd43, 7'd4, 7'd2, 7'd10, 7'd11, 7'd12, 7'd13, 7'd63};
        reset = 1'b1;
        drive(7'd0, 1'b0, 1'b0);
        #1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        r_op = 7'd0;
        r_v  = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (busy_rem == 0) begin
                if ($urandom_range(0, 7) == 0) r_op = 7'($urandom_range(0, 127));
                else r_op = op_pool[$urandom_range(0, 10)];
                r_v = ($urandom_range(0, 3) != 0);
            end
            r_f = ($urandom_range(0, 4) == 0);
            drive(r_op, r_v, r_f);
            tick();
            model_step(int'(r_op), r_v, r_f);
            check($sformatf("rand%0d_op%0d", n, r_op), model_exp());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
